ibuf_unpacker: RTL and testbench
================================

Name: ibuf_unpacker

Overview:
- Sits between the instruction-buffer FIFO (fetch side) and the dual-issue decode stage.
- Each FIFO entry is one fetch packet: up to four 32-bit instructions, a base PC and a per-slot valid mask.
- Extracts up to two valid instructions per cycle in slot order, with their PCs, into a registered output stage.
- Tracks partial consumption of the head entry and pops the FIFO when the last valid slot is taken.

Parameters:
- INST_W, 32, width of one instruction.
- PC_W, 32, PC width.
- SLOTS, 4, instructions per fetch packet; fixed at 4 in this revision.
- PKT_W, 164, packet width; always SLOTS*INST_W + PC_W + SLOTS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (branch mispredict / exception); same cycle as the FIFO flush
- fifo_data  in  PKT_W  head entry. [127:0] instructions, slot k at [32k+31:32k]; [159:128] base_pc; [163:160] valid mask, bit k = slot k
- fifo_empty  in  1  FIFO empty flag
- fifo_pop  out  1  pop request to the FIFO (combinational)
- dec_ready  in  1  decode accepts the current output pair (all-or-nothing)
- out_valid  out  2  bit0 = lane0 valid, bit1 = lane1 valid; bit1 implies bit0
- out_inst0 / out_inst1  out  INST_W each  instructions for lanes 0 / 1
- out_pc0 / out_pc1  out  PC_W each  PCs for lanes 0 / 1; slot k PC = base_pc + 4*k

Behaviour:
- State: consumed[3:0] (slots of the head entry already emitted) plus the output registers.
- remaining = valid_mask & ~consumed.
- sel0 = lowest set bit of remaining; sel1 = next set bit above sel0.
- Never combine slots from two different entries in one output pair.
- load = (out_valid == 0) | dec_ready.
- take = load & ~fifo_empty & ~flush.
- last = no set bit of remaining remains after removing sel0 and sel1. This includes remaining == 0.
- fifo_pop = take & last.
- On take: out_valid <= {sel1 exists, sel0 exists}; lane data/PCs <= selected slots.
  - If last: consumed <= 0.
  - Else: consumed <= consumed | sel0 | sel1.
- load & fifo_empty & ~flush: out_valid <= 0; consumed unchanged.
- ~load: all output registers and consumed hold (backpressure). fifo_pop = 0.
- Entry with valid_mask == 0: popped in one cycle with out_valid <= 0. No bubble beyond that cycle.
- Latency: an entry at the head with fifo_empty = 0 at cycle t produces out_valid at t+1.
- Throughput: 2 instructions/cycle while dec_ready stays high.
- PC arithmetic is modulo 2^PC_W; wrap-around is not flagged.
- Flush (highest priority after rst): out_valid <= 0, consumed <= 0, fifo_pop = 0 that cycle. No instruction from before the flush appears afterwards.
- Reset: out_valid = 0, consumed = 0, out_inst*/out_pc* = 0, fifo_pop = 0.
- Reset or flush mid-packet discards the partially consumed entry state.
- out_inst/out_pc of an invalid lane are don't-care but must be stable while held.

Decomposition:
- Shared package: SLOTS, INST_W, PC_W, PKT_W, and packet field offset constants (PKT_INST_LSB, PKT_PC_LSB, PKT_MASK_LSB). The FIFO instance uses PKT_W.
- One natural sub-module: ibuf_slot_pick. Purely combinational; takes remaining[3:0] and returns sel0/sel1 one-hot masks, their valid bits, and last.

Test Plan:
- mask 1111, base_pc 0x1c000000, dec_ready = 1:
  - Cycle 1: pair PCs 0x1c000000 / 0x1c000004, no pop.
  - Cycle 2: pair PCs 0x1c000008 / 0x1c00000c with fifo_pop = 1.
- mask 0110, base 0x1c000010: single pair PCs 0x1c000014 / 0x1c000018, fifo_pop = 1 on that take.
- mask 1011, base 0x1c000020:
  - Pair 0x1c000020 / 0x1c000024.
  - Then out_valid = 01, PC 0x1c00002c, pop.
  - The next entry is not merged into lane1.
- dec_ready low 3 cycles with mask 1111 at the head: outputs hold slot0/1, fifo_pop = 0, consumed unchanged. Release resumes with slots 2/3.
- flush asserted after the first pair of a 1111 entry: next cycle out_valid = 00, consumed = 0. A new entry (mask 0001, base 0x1c000100) then emits lane0 PC 0x1c000100 only.
- mask 0000 entry followed by mask 0001 entry:
  - Cycle 1: empty entry popped, out_valid = 00.
  - Cycle 2: second entry popped, its instruction appears.
  - Also covered: rst mid-entry clears all outputs to 0.

Source files
------------

// File: rtl/ibuf_unpacker_pkg.sv
// Shared constants for the instruction-buffer unpacker: packet geometry and field offsets.
// The FIFO that feeds the unpacker is sized with PKT_W.
package ibuf_unpacker_pkg;

    localparam int SLOTS  = 4;
    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int PKT_W  = SLOTS*INST_W + PC_W + SLOTS;

    localparam int PKT_INST_LSB = 0;
    localparam int PKT_PC_LSB   = SLOTS*INST_W;
    localparam int PKT_MASK_LSB = PKT_PC_LSB + PC_W;

    // Isolates the lowest set bit of a slot mask (zero in, zero out).
    function automatic logic [SLOTS-1:0] lowest_bit(input logic [SLOTS-1:0] m);
        return m & (~m + {{(SLOTS-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/ibuf_slot_pick.sv
// Picks the two lowest remaining slots of the head packet as one-hot masks and
// reports whether they exhaust the packet.
module ibuf_slot_pick
    import ibuf_unpacker_pkg::*;
(
    input  logic [SLOTS-1:0] remaining,
    output logic [SLOTS-1:0] sel0,
    output logic [SLOTS-1:0] sel1,
    output logic             sel0_valid,
    output logic             sel1_valid,
    output logic             last
);

    logic [SLOTS-1:0] after_sel0;

    assign sel0       = lowest_bit(remaining);
    assign after_sel0 = remaining & ~sel0;
    assign sel1       = lowest_bit(after_sel0);
    assign sel0_valid = |sel0;
    assign sel1_valid = |sel1;

    // An empty packet counts as exhausted so it is popped without emitting anything.
    assign last = ~|(after_sel0 & ~sel1);

endmodule

// File: rtl/ibuf_unpacker.sv
// Unpacks fetch packets from the instruction-buffer FIFO into a registered
// dual-issue output pair, popping the FIFO once the head packet is exhausted.
module ibuf_unpacker
    import ibuf_unpacker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [PKT_W-1:0]  fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    input  logic              dec_ready,
    output logic [1:0]        out_valid,
    output logic [INST_W-1:0] out_inst0,
    output logic [INST_W-1:0] out_inst1,
    output logic [PC_W-1:0]   out_pc0,
    output logic [PC_W-1:0]   out_pc1
);

    logic [SLOTS-1:0]  valid_mask;
    logic [PC_W-1:0]   base_pc;
    logic [INST_W-1:0] slot_inst [SLOTS];
    logic [PC_W-1:0]   slot_pc   [SLOTS];

    logic [SLOTS-1:0]  consumed_reg;
    logic [SLOTS-1:0]  consumed_next;
    logic [SLOTS-1:0]  remaining;
    logic [SLOTS-1:0]  sel0;
    logic [SLOTS-1:0]  sel1;
    logic              sel0_valid;
    logic              sel1_valid;
    logic              last;

    logic              load;
    logic              take;

    logic [1:0]        valid_reg;
    logic [INST_W-1:0] inst0_reg, inst1_reg, inst0_next, inst1_next;
    logic [PC_W-1:0]   pc0_reg, pc1_reg, pc0_next, pc1_next;

    assign valid_mask = fifo_data[PKT_MASK_LSB +: SLOTS];
    assign base_pc    = fifo_data[PKT_PC_LSB +: PC_W];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign slot_inst[gi] = fifo_data[PKT_INST_LSB + gi*INST_W +: INST_W];
            // PC wraps modulo 2^PC_W without any indication.
            assign slot_pc[gi]   = base_pc + PC_W'(4*gi);
        end
    endgenerate

    assign remaining = valid_mask & ~consumed_reg;

    ibuf_slot_pick u_pick (
        .remaining  (remaining),
        .sel0       (sel0),
        .sel1       (sel1),
        .sel0_valid (sel0_valid),
        .sel1_valid (sel1_valid),
        .last       (last)
    );

    assign load     = (valid_reg == 2'b00) | dec_ready;
    assign take     = load & ~fifo_empty & ~flush & ~rst;
    assign fifo_pop = take & last;

    assign consumed_next = last ? '0 : (consumed_reg | sel0 | sel1);

    // One-hot AND-OR mux; an absent lane yields zero data.
    always_comb begin
        inst0_next = '0;
        inst1_next = '0;
        pc0_next   = '0;
        pc1_next   = '0;
        for (int k = 0; k < SLOTS; k++) begin
            inst0_next = inst0_next | ({INST_W{sel0[k]}} & slot_inst[k]);
            inst1_next = inst1_next | ({INST_W{sel1[k]}} & slot_inst[k]);
            pc0_next   = pc0_next   | ({PC_W{sel0[k]}}   & slot_pc[k]);
            pc1_next   = pc1_next   | ({PC_W{sel1[k]}}   & slot_pc[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 2'b00;
            consumed_reg <= '0;
            inst0_reg    <= '0;
            inst1_reg    <= '0;
            pc0_reg      <= '0;
            pc1_reg      <= '0;
        end else if (flush) begin
            valid_reg    <= 2'b00;
            consumed_reg <= '0;
        end else if (take) begin
            valid_reg    <= {sel1_valid, sel0_valid};
            inst0_reg    <= inst0_next;
            inst1_reg    <= inst1_next;
            pc0_reg      <= pc0_next;
            pc1_reg      <= pc1_next;
            consumed_reg <= consumed_next;
        end else if (load) begin
            // Decode drained the pair but the FIFO is empty: go idle.
            valid_reg    <= 2'b00;
        end
    end

    assign out_valid = valid_reg;
    assign out_inst0 = inst0_reg;
    assign out_inst1 = inst1_reg;
    assign out_pc0   = pc0_reg;
    assign out_pc1   = pc1_reg;

endmodule

// File: tb/tb_ibuf_unpacker.sv
// Directed bench for ibuf_unpacker: a queue models the FIFO and a scoreboard of
// expected output pairs is filled at push time and drained as decode accepts pairs.
module tb_ibuf_unpacker;
    import ibuf_unpacker_pkg::*;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [31:0] p0;
        logic [31:0] p1;
    } pair_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [PKT_W-1:0]  fifo_data;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              dec_ready;
    logic [1:0]        out_valid;
    logic [INST_W-1:0] out_inst0;
    logic [INST_W-1:0] out_inst1;
    logic [PC_W-1:0]   out_pc0;
    logic [PC_W-1:0]   out_pc1;

    logic [PKT_W-1:0] fifo_q [$];
    pair_t            sb [$];
    int               checks;
    int               errors;
    logic             p;

    ibuf_unpacker dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .dec_ready  (dec_ready),
        .out_valid  (out_valid),
        .out_inst0  (out_inst0),
        .out_inst1  (out_inst1),
        .out_pc0    (out_pc0),
        .out_pc1    (out_pc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [7:0] tag, input int k);
        return {16'hC0DE, tag, 8'(k)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push_entry(input logic [3:0] m, input logic [31:0] base, input logic [7:0] tag);
        logic [PKT_W-1:0] pkt;
        int               idx[$];
        pair_t            pr;
        pkt = '0;
        for (int k = 0; k < 4; k++) pkt[32*k +: 32] = inst_of(tag, k);
        pkt[159:128] = base;
        pkt[163:160] = m;
        fifo_q.push_back(pkt);
        for (int k = 0; k < 4; k++) if (m[k]) idx.push_back(k);
        for (int j = 0; j < idx.size(); j += 2) begin
            pr.v  = (j + 1 < idx.size()) ? 2'b11 : 2'b01;
            pr.i0 = inst_of(tag, idx[j]);
            pr.p0 = base + 32'(4*idx[j]);
            if (pr.v[1]) begin
                pr.i1 = inst_of(tag, idx[j+1]);
                pr.p1 = base + 32'(4*idx[j+1]);
            end else begin
                pr.i1 = '0;
                pr.p1 = '0;
            end
            sb.push_back(pr);
        end
        refresh();
    endtask

    task automatic check_pair();
        pair_t e;
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            $display("pair accepted: v=%b pc0=%h inst0=%h pc1=%h inst1=%h",
                     out_valid, out_pc0, out_inst0, out_pc1, out_inst1);
            check("pair_valid", 64'(out_valid), 64'(e.v));
            check("pair_inst0", 64'(out_inst0), 64'(e.i0));
            check("pair_pc0",   64'(out_pc0),   64'(e.p0));
            if (e.v[1]) begin
                check("pair_inst1", 64'(out_inst1), 64'(e.i1));
                check("pair_pc1",   64'(out_pc1),   64'(e.p1));
            end
        end
    endtask

    // One clock: snapshot at the falling edge, then model the FIFO pop after the rising edge.
    task automatic step(output logic popped);
        @(negedge clk);
        popped = fifo_pop;
        if (!rst && !flush && dec_ready && out_valid != 2'b00) check_pair();
        @(posedge clk);
        #1;
        if (popped === 1'b1 && fifo_q.size() != 0) fifo_q.delete(0);
        refresh();
    endtask

    task automatic expect_out(input string tag, input logic [1:0] v,
                              input logic [31:0] pc0, input logic [31:0] pc1);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        if (v[0]) check({tag, "_pc0"}, 64'(out_pc0), 64'(pc0));
        if (v[1]) check({tag, "_pc1"}, 64'(out_pc1), 64'(pc1));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        dec_ready = 1'b1;
        refresh();

        step(p);
        step(p);
        check("rst_pop",   64'(p), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_inst0", 64'(out_inst0), 64'd0);
        check("rst_pc1",   64'(out_pc1), 64'd0);
        rst = 1'b0;

        // Full packet: two pairs back to back, pop on the second.
        push_entry(4'b1111, 32'h1c000000, 8'h01);
        step(p); check("a_pop1", 64'(p), 64'd0);
        expect_out("a1", 2'b11, 32'h1c000000, 32'h1c000004);
        step(p); check("a_pop2", 64'(p), 64'd1);
        expect_out("a2", 2'b11, 32'h1c000008, 32'h1c00000c);

        push_entry(4'b0110, 32'h1c000010, 8'h02);
        step(p); check("b_pop", 64'(p), 64'd1);
        expect_out("b", 2'b11, 32'h1c000014, 32'h1c000018);

        // Odd slot count: last slot goes out alone, next packet not merged.
        push_entry(4'b1011, 32'h1c000020, 8'h03);
        push_entry(4'b0001, 32'h1c000030, 8'h04);
        step(p); check("c_pop1", 64'(p), 64'd0);
        expect_out("c1", 2'b11, 32'h1c000020, 32'h1c000024);
        step(p); check("c_pop2", 64'(p), 64'd1);
        expect_out("c2", 2'b01, 32'h1c00002c, 32'h0);
        step(p); check("d_pop", 64'(p), 64'd1);
        expect_out("d", 2'b01, 32'h1c000030, 32'h0);
        step(p); check("idle_pop", 64'(p), 64'd0);
        expect_out("idle", 2'b00, 32'h0, 32'h0);

        // Backpressure for three cycles.
        push_entry(4'b1111, 32'h1c000040, 8'h05);
        step(p); expect_out("bp0", 2'b11, 32'h1c000040, 32'h1c000044);
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(p); check("bp_pop", 64'(p), 64'd0);
            expect_out("bp_hold", 2'b11, 32'h1c000040, 32'h1c000044);
            check("bp_inst0", 64'(out_inst0), 64'(inst_of(8'h05, 0)));
        end
        dec_ready = 1'b1;
        step(p); check("bp_rel_pop", 64'(p), 64'd1);
        expect_out("bp_rel", 2'b11, 32'h1c000048, 32'h1c00004c);

        // PC wrap-around.
        push_entry(4'b1100, 32'hfffffff8, 8'h06);
        step(p); check("wrap_pop", 64'(p), 64'd1);
        expect_out("wrap", 2'b11, 32'h00000000, 32'h00000004);

        // Flush after the first pair of a full packet.
        push_entry(4'b1111, 32'h1c000080, 8'h07);
        step(p); expect_out("fl0", 2'b11, 32'h1c000080, 32'h1c000084);
        flush = 1'b1;
        fifo_q.delete();
        sb.delete();
        refresh();
        step(p); check("fl_pop", 64'(p), 64'd0);
        expect_out("fl", 2'b00, 32'h0, 32'h0);
        flush = 1'b0;
        push_entry(4'b0001, 32'h1c000100, 8'h08);
        step(p); check("post_fl_pop", 64'(p), 64'd1);
        expect_out("post_fl", 2'b01, 32'h1c000100, 32'h0);
        check("post_fl_inst0", 64'(out_inst0), 64'(inst_of(8'h08, 0)));

        // Empty-mask packet popped in one cycle.
        push_entry(4'b0000, 32'h1c000200, 8'h09);
        push_entry(4'b0001, 32'h1c000210, 8'h0a);
        step(p); check("e0_pop", 64'(p), 64'd1);
        expect_out("e0", 2'b00, 32'h0, 32'h0);
        step(p); check("e1_pop", 64'(p), 64'd1);
        expect_out("e1", 2'b01, 32'h1c000210, 32'h0);

        // Reset in the middle of a packet.
        push_entry(4'b1111, 32'h1c000300, 8'h0b);
        step(p); expect_out("rm0", 2'b11, 32'h1c000300, 32'h1c000304);
        rst = 1'b1;
        sb.delete();
        step(p); check("rm_pop", 64'(p), 64'd0);
        check("rm_valid", 64'(out_valid), 64'd0);
        check("rm_inst0", 64'(out_inst0), 64'd0);
        check("rm_inst1", 64'(out_inst1), 64'd0);
        check("rm_pc0",   64'(out_pc0), 64'd0);
        check("rm_pc1",   64'(out_pc1), 64'd0);
        rst = 1'b0;
        fifo_q.delete();
        refresh();
        step(p);
        step(p);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
